// File: rtl/enc_velocity_sampler_pkg.sv
// Shared definitions for the wheel encoder velocity sampler: step encoding,
// quadrature transition lookup and default widths.
package enc_velocity_sampler_pkg;

    localparam int COUNT_W_DEF = 12;
    localparam int POS_W_DEF   = 16;
    localparam int ERR_W       = 8;
    localparam int ERR_MAX     = 255;

    typedef logic signed [1:0] step_t;

    localparam step_t STEP_FWD  = 2'sb01;
    localparam step_t STEP_REV  = 2'sb11;
    localparam step_t STEP_NONE = 2'sb00;

    typedef struct packed {
        step_t step;
        logic  illegal;
    } trans_t;

    // States are {A,B}; forward rotation walks 00 -> 10 -> 11 -> 01 -> 00.
    function automatic trans_t trans_lookup(input logic [1:0] prev, input logic [1:0] cur);
        trans_t t;
        t.step    = STEP_NONE;
        t.illegal = 1'b0;
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: t.step    = STEP_FWD;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: t.step    = STEP_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: t.illegal = 1'b1;
            default: ;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/enc_velocity_sampler_if.sv
// Velocity/position result bus published once per control window.
interface enc_velocity_sampler_if
    import enc_velocity_sampler_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int POS_W   = POS_W_DEF
);
    logic signed [COUNT_W-1:0] vel_count;
    logic                      vel_valid;
    logic                      vel_sat;
    logic signed [POS_W-1:0]   position;
    logic [ERR_W-1:0]          err_cnt;

    modport master (output vel_count, vel_valid, vel_sat, position, err_cnt);
    modport slave  (input  vel_count, vel_valid, vel_sat, position, err_cnt);
endinterface

// File: rtl/enc_velocity_sampler_quad_decoder.sv
// 4x quadrature decoder: synchronises A/B and emits a signed step per clock
// plus a pulse on any transition that flips both channels at once.
module quad_decoder
    import enc_velocity_sampler_pkg::*;
#(
    parameter int DIR_INV = 0
) (
    input  logic  clk_256kHz,
    input  logic  reset,
    input  logic  enc_a,
    input  logic  enc_b,
    output step_t step,
    output logic  illegal
);
    logic [1:0] sync1, sync2, prev;
    logic [2:0] warm;
    trans_t     trans;

    // warm[2] holds off decoding until prev has captured a real synced sample.
    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            prev  <= 2'b00;
            warm  <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge value of its source.
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            prev  <= sync2;
            warm  <= {warm[1:0], 1'b1};
        end
    end

    assign trans = trans_lookup(prev, sync2);

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        step    = STEP_NONE;
        illegal = 1'b0;
        if (warm[2]) begin
            illegal = trans.illegal;
            step    = (DIR_INV != 0) ? step_t'(-trans.step) : trans.step;
        end
    end

endmodule

// File: rtl/enc_velocity_sampler.sv
// Per-wheel velocity sampler: accumulates encoder steps over each 80 Hz window
// and publishes a saturated per-window count plus a free-running position.
module enc_velocity_sampler
    import enc_velocity_sampler_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int POS_W   = POS_W_DEF,
    parameter int DIR_INV = 0
) (
    input  logic                   clk_256kHz,
    input  logic                   reset,
    input  logic                   clk_80Hz_in,
    input  logic                   enc_a,
    input  logic                   enc_b,
    enc_velocity_sampler_if.master vel_bus
);
    localparam logic signed [COUNT_W:0] SUM_MAX = {2'b00, {(COUNT_W-1){1'b1}}};
    localparam logic signed [COUNT_W:0] SUM_MIN = {2'b11, {(COUNT_W-1){1'b0}}};

    logic tick_sync1, tick_sync2, tick_prev, tick_rise;
    step_t step;
    logic  illegal;

    logic signed [COUNT_W-1:0] acc, acc_clamped, vel_count;
    logic signed [COUNT_W:0]   acc_sum;
    logic signed [POS_W-1:0]   position;
    logic [ERR_W-1:0]          err_cnt;
    logic sat_win, clamp_now, first_win, vel_valid, vel_sat;

    quad_decoder #(.DIR_INV(DIR_INV)) u_quad_decoder (
        .clk_256kHz (clk_256kHz),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .step       (step),
        .illegal    (illegal)
    );

    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset) begin
            tick_sync1 <= 1'b0;
            tick_sync2 <= 1'b0;
            tick_prev  <= 1'b0;
        end else begin
            tick_sync1 <= clk_80Hz_in;
            tick_sync2 <= tick_sync1;
            tick_prev  <= tick_sync2;
        end
    end

    assign tick_rise = tick_sync2 & ~tick_prev;

    // One guard bit lets the clamp see an overflow before it wraps.
    always_comb begin
        acc_sum     = {acc[COUNT_W-1], acc} + {{(COUNT_W-1){step[1]}}, step};
        acc_clamped = acc_sum[COUNT_W-1:0];
        clamp_now   = 1'b0;
        if (acc_sum > SUM_MAX) begin
            acc_clamped = SUM_MAX[COUNT_W-1:0];
            clamp_now   = 1'b1;
        end else if (acc_sum < SUM_MIN) begin
            acc_clamped = SUM_MIN[COUNT_W-1:0];
            clamp_now   = 1'b1;
        end
    end

    always_ff @(posedge clk_256kHz or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            sat_win   <= 1'b0;
            first_win <= 1'b1;
            vel_count <= '0;
            vel_valid <= 1'b0;
            vel_sat   <= 1'b0;
            position  <= '0;
            err_cnt   <= '0;
        end else begin
            position  <= position + {{(POS_W-2){step[1]}}, step};
            vel_valid <= 1'b0;
            if (illegal && err_cnt != ERR_W'(ERR_MAX))
                err_cnt <= err_cnt + 1'b1;
            // The step landing on the tick cycle closes out with the old window.
            if (tick_rise) begin
                acc     <= '0;
                sat_win <= 1'b0;
                if (first_win) begin
                    first_win <= 1'b0;
                end else begin
                    vel_count <= acc_clamped;
                    vel_sat   <= sat_win | clamp_now;
                    vel_valid <= 1'b1;
                end
            end else begin
                acc     <= acc_clamped;
                sat_win <= sat_win | clamp_now;
            end
        end
    end

    assign vel_bus.vel_count = vel_count;
    assign vel_bus.vel_valid = vel_valid;
    assign vel_bus.vel_sat   = vel_sat;
    assign vel_bus.position  = position;
    assign vel_bus.err_cnt   = err_cnt;

endmodule

// File: tb/tb_enc_velocity_sampler.sv
// Bench for enc_velocity_sampler: a normal and a direction-inverted instance
// share encoder/tick stimulus and are checked against an arithmetic wheel model.
`timescale 1ns/1ps
module tb_enc_velocity_sampler;

    localparam int CW = 12;
    localparam int PW = 16;
    localparam int CMAX = 2047;
    localparam int CMIN = -2048;

    logic clk_256kHz = 1'b0;
    logic reset = 1'b0;
    logic clk_80Hz_in = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;

    always #5 clk_256kHz = ~clk_256kHz;

    enc_velocity_sampler_if #(.COUNT_W(CW), .POS_W(PW)) bus_n ();
    enc_velocity_sampler_if #(.COUNT_W(CW), .POS_W(PW)) bus_i ();

    enc_velocity_sampler #(.COUNT_W(CW), .POS_W(PW), .DIR_INV(0)) dut_n (
        .clk_256kHz (clk_256kHz),
        .reset      (reset),
        .clk_80Hz_in(clk_80Hz_in),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .vel_bus    (bus_n)
    );

    enc_velocity_sampler #(.COUNT_W(CW), .POS_W(PW), .DIR_INV(1)) dut_i (
        .clk_256kHz (clk_256kHz),
        .reset      (reset),
        .clk_80Hz_in(clk_80Hz_in),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .vel_bus    (bus_i)
    );

    // Wheel model: index 0 = normal instance, 1 = mirrored instance.
    int win_m[2];
    bit sat_m[2];
    int vc_m[2];
    bit vs_m[2];
    int pos_m[2];
    int err_m;
    bit first_m;
    int phase;
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check_valid(input string tag, input bit exp);
        check($sformatf("%s[0].vel_valid", tag), bus_n.vel_valid, 32'(exp));
        check($sformatf("%s[1].vel_valid", tag), bus_i.vel_valid, 32'(exp));
    endtask

    task automatic check_outputs(input string tag, input bit exp_valid);
        logic signed [31:0] vc, pos;
        logic vv, vs;
        logic [7:0] ec;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                vc = bus_n.vel_count; pos = bus_n.position;
                vv = bus_n.vel_valid; vs = bus_n.vel_sat; ec = bus_n.err_cnt;
            end else begin
                vc = bus_i.vel_count; pos = bus_i.position;
                vv = bus_i.vel_valid; vs = bus_i.vel_sat; ec = bus_i.err_cnt;
            end
            check($sformatf("%s[%0d].vel_valid", tag, i), vv, 32'(exp_valid));
            check($sformatf("%s[%0d].vel_count", tag, i), vc, vc_m[i]);
            check($sformatf("%s[%0d].vel_sat", tag, i), vs, 32'(vs_m[i]));
            check($sformatf("%s[%0d].position", tag, i), pos, pos_m[i]);
            check($sformatf("%s[%0d].err_cnt", tag, i), ec, err_m);
        end
    endtask

    // d = phase advance: 0 hold, 1 forward, 3 reverse, 2 illegal jump.
    task automatic move(input int d, input int gap);
        int s, si;
        phase = (phase + d) % 4;
        {enc_a, enc_b} = gray(phase);
        if (d == 2) begin
            if (err_m < 255) err_m++;
        end else if (d == 1 || d == 3) begin
            s = (d == 1) ? 1 : -1;
            for (int i = 0; i < 2; i++) begin
                si = (i == 1) ? -s : s;
                win_m[i] += si;
                if (win_m[i] > CMAX) begin win_m[i] = CMAX; sat_m[i] = 1'b1; end
                if (win_m[i] < CMIN) begin win_m[i] = CMIN; sat_m[i] = 1'b1; end
                pos_m[i] += si;
                if (pos_m[i] > 32767) pos_m[i] -= 65536;
                else if (pos_m[i] < -32768) pos_m[i] += 65536;
            end
        end
        repeat (gap) @(negedge clk_256kHz);
    endtask

    task automatic do_tick(input string tag);
        bit ev;
        ev = !first_m;
        if (first_m) first_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ev) begin vc_m[i] = win_m[i]; vs_m[i] = sat_m[i]; end
            win_m[i] = 0;
            sat_m[i] = 1'b0;
        end
        clk_80Hz_in = 1'b1;
        repeat (2) @(negedge clk_256kHz);
        check_valid({tag, ".early"}, 1'b0);
        @(negedge clk_256kHz);
        check_outputs(tag, ev);
        @(negedge clk_256kHz);
        check_valid({tag, ".pulse_end"}, 1'b0);
        repeat (2) @(negedge clk_256kHz);
        clk_80Hz_in = 1'b0;
        repeat (4) @(negedge clk_256kHz);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            win_m[i] = 0; sat_m[i] = 1'b0; vc_m[i] = 0; vs_m[i] = 1'b0; pos_m[i] = 0;
        end
        err_m = 0;
        first_m = 1'b1;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag, 1'b0);
        repeat (3) @(negedge clk_256kHz);
        reset = 1'b0;
        repeat (5) @(negedge clk_256kHz);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d;
        phase = 0;
        @(negedge clk_256kHz);
        pulse_reset("reset");

        // Idle encoder: first tick discarded, second publishes zero.
        do_tick("t1_first");
        do_tick("t1_second");

        for (int k = 0; k < 100; k++) move(1, 8);
        do_tick("t2_fwd100");
        check("t2_fwd_count", bus_n.vel_count, 100);
        for (int k = 0; k < 100; k++) move(3, 8);
        do_tick("t2_rev100");
        check("t2_rev_pos", bus_n.position, 0);

        for (int k = 0; k < 40; k++) move(1, 3);
        do_tick("t3_fwd40");
        check("t3_inv_count", bus_i.vel_count, -40);

        for (int w = 0; w < 4; w++) begin
            n = $urandom_range(20, 80);
            for (int k = 0; k < n; k++) begin
                d = $urandom_range(0, 3);
                if (d == 2 && $urandom_range(0, 7) != 0) d = 1;
                move(d, $urandom_range(2, 5));
            end
            do_tick($sformatf("rand_w%0d", w));
        end

        for (int k = 0; k < 3000; k++) move(1, 2);
        do_tick("t4_sat");
        check("t4_sat_count", bus_n.vel_count, 2047);
        check("t4_sat_flag", bus_n.vel_sat, 1);
        for (int k = 0; k < 10; k++) move(1, 4);
        do_tick("t4_recover");
        check("t4_recover_sat", bus_n.vel_sat, 0);

        for (int k = 0; k < 300; k++) begin
            if (phase != 0) move(4 - phase, 2);
            move(2, 2);
        end
        do_tick("t5_illegal");
        check("t5_err_sat", bus_n.err_cnt, 255);

        // Edge in the tick-rise cycle belongs to the closing window.
        move(1, 6);
        move(1, 0);
        do_tick("t6_edge_on_tick");
        for (int k = 0; k < 5; k++) move(1, 3);
        pulse_reset("t6_mid_reset");
        do_tick("t6_after_reset");
        for (int k = 0; k < 3; k++) move(3, 3);
        do_tick("t6_resume");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
